// File: rtl/suma_pf_seq.sv
`timescale 1ns/1ps
// suma_pf_seq -- multi-cycle handshaked floating-point adder/subtractor.
//
// Operands are IEEE-754 style words {sign, exp, man} with bias 2^(EXP_W-1)-1.
// Each operation runs through align / add / normalise / round.
// Denormal inputs are flushed to zero. NaN and Inf operands are resolved
// early, but they still follow the same path, so latency is always 4 edges
// from accept to out_valid.
//
// Rounding mode is set at build time by the macro SUMA_PF_RNE_EN:
//   defined   : round-to-nearest-even, overflow gives +/-Inf
//   undefined : truncate toward zero, overflow saturates to max finite
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op valid
//   in_ready   block can accept (IDLE only)
//   a, b       operands, W = 1+EXP_W+MAN_W bits
//   op         0 = a+b, 1 = a-b
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer accepts result
//   result     sum / difference
//   flags      {invalid, overflow, underflow, inexact}
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ALIGN | unpack, detect specials, swap, align smaller significand
// ADD   | add or subtract aligned significands
// NORM  | normalise, detect underflow or exact zero
// ROUND | round, detect overflow, register result and flags
// DONE  | result presented until out_ready
module suma_pf_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int M   = MAN_W + 4;          // hidden, mantissa, guard, round, sticky
   localparam int XW  = EXP_W + 2;          // signed working exponent
   localparam int LZW = $clog2(M + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ALIGN = 3'd1;
   localparam logic [2:0] ADD   = 3'd2;
   localparam logic [2:0] NORM  = 3'd3;
   localparam logic [2:0] ROUND = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic [2:0]              state;
   logic [W-1:0]            aReg, bReg;
   logic [M-1:0]            bigSig, smallSig, normSig;
   logic                    bigSign, effSub, resSign;
   logic signed [XW-1:0]    expReg;
   logic [M:0]              sumReg;
   logic                    forceEn;
   logic [W-1:0]            forceRes;
   logic [3:0]              forceFlags;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // ---------------- ALIGN datapath ----------------
   logic                aSign, bSign, aZero, bZero, aInf, bInf, aNan, bNan, swap;
   logic [EXP_W-1:0]    aExp, bExp, bigExpC, smallExpC, expDiff;
   logic [MAN_W-1:0]    aMan, bMan;
   logic [W-2:0]        aMag, bMag;
   logic [M-1:0]        aSigC, bSigC, bigSigC, smallSigC, smallAligned;
   logic [2*M-1:0]      shExt;
   logic                specNan, specInf;
   logic [W-1:0]        specRes;

   assign aSign = aReg[W-1];
   assign bSign = bReg[W-1];
   assign aExp  = aReg[W-2:MAN_W];
   assign bExp  = bReg[W-2:MAN_W];
   assign aMan  = aReg[MAN_W-1:0];
   assign bMan  = bReg[MAN_W-1:0];
   assign aZero = (aExp == '0);
   assign bZero = (bExp == '0);
   assign aInf  = (aExp == '1) && (aMan == '0);
   assign bInf  = (bExp == '1) && (bMan == '0);
   assign aNan  = (aExp == '1) && (aMan != '0);
   assign bNan  = (bExp == '1) && (bMan != '0);

   // Flushed denormals compare as zero magnitude.
   assign aMag  = aZero ? '0 : aReg[W-2:0];
   assign bMag  = bZero ? '0 : bReg[W-2:0];
   assign swap  = (bMag > aMag);

   assign aSigC     = aZero ? '0 : {1'b1, aMan, 3'b000};
   assign bSigC     = bZero ? '0 : {1'b1, bMan, 3'b000};
   assign bigSigC   = swap ? bSigC : aSigC;
   assign smallSigC = swap ? aSigC : bSigC;
   assign bigExpC   = swap ? bExp : aExp;
   assign smallExpC = swap ? aExp : bExp;
   assign expDiff   = bigExpC - smallExpC;

   always_comb begin
      shExt        = '0;
      smallAligned = '0;
      if (int'(expDiff) > M - 1) begin
         smallAligned = {{(M-1){1'b0}}, |smallSigC};
      end else begin
         // Low half of the extended vector holds everything shifted out.
         shExt        = {smallSigC, {M{1'b0}}} >> expDiff;
         smallAligned = shExt[2*M-1:M] | {{(M-1){1'b0}}, |shExt[M-1:0]};
      end
   end

   assign specNan = aNan | bNan | (aInf & bInf & (aSign ^ bSign));
   assign specInf = aInf | bInf;
   assign specRes = specNan ? QNAN : {(aInf ? aSign : bSign), {EXP_W{1'b1}}, {MAN_W{1'b0}}};

   // ---------------- ADD datapath ----------------
   logic [M:0] sumC;
   assign sumC = effSub ? ({1'b0, bigSig} - {1'b0, smallSig})
                        : ({1'b0, bigSig} + {1'b0, smallSig});

   // ---------------- NORM datapath ----------------
   logic [LZW-1:0]       lz;
   logic signed [XW-1:0] lzExt, normExpC;
   logic [M-1:0]         normShifted;

   always_comb begin
      lz = LZW'(M);
      for (int i = 0; i < M; i++) begin
         if (sumReg[i]) lz = LZW'(M - 1 - i);
      end
   end

   assign lzExt       = XW'(lz);
   assign normExpC    = expReg - lzExt;
   assign normShifted = sumReg[M-1:0] << lz;

   // ---------------- ROUND datapath ----------------
   logic [MAN_W:0]       mantC;
   logic                 roundInc, inexactC, ovfC;
   logic [MAN_W+1:0]     roundedC;
   logic signed [XW-1:0] finalExp;
   logic [MAN_W-1:0]     finalMan;
   logic [W-1:0]         ovfRes, roundRes;
   logic [3:0]           roundFlags;

   assign mantC    = normSig[M-1:3];
   assign inexactC = |normSig[2:0];
`ifdef SUMA_PF_RNE_EN
   assign roundInc = normSig[2] & (normSig[1] | normSig[0] | mantC[0]);
   assign ovfRes   = {resSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
   assign roundInc = 1'b0;
   assign ovfRes   = {resSign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
   assign roundedC   = {1'b0, mantC} + {{(MAN_W+1){1'b0}}, roundInc};
   assign finalExp   = roundedC[MAN_W+1] ? (expReg + EXP_ONE) : expReg;
   assign finalMan   = roundedC[MAN_W+1] ? roundedC[MAN_W:1] : roundedC[MAN_W-1:0];
   assign ovfC       = (finalExp >= EXP_MAX);
   assign roundRes   = ovfC ? ovfRes : {resSign, finalExp[EXP_W-1:0], finalMan};
   assign roundFlags = ovfC ? 4'b0101 : {3'b000, inexactC};

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         aReg       <= '0;
         bReg       <= '0;
         bigSig     <= '0;
         smallSig   <= '0;
         normSig    <= '0;
         bigSign    <= 1'b0;
         effSub     <= 1'b0;
         resSign    <= 1'b0;
         expReg     <= '0;
         sumReg     <= '0;
         forceEn    <= 1'b0;
         forceRes   <= '0;
         forceFlags <= '0;
         result     <= '0;
         flags      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  aReg  <= a;
                  bReg  <= {b[W-1] ^ op, b[W-2:0]};
                  flags <= '0;
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               bigSig     <= bigSigC;
               smallSig   <= smallAligned;
               expReg     <= $signed({2'b00, bigExpC});
               bigSign    <= swap ? bSign : aSign;
               effSub     <= aSign ^ bSign;
               forceEn    <= specNan | specInf;
               forceRes   <= specRes;
               forceFlags <= specNan ? 4'b1000 : 4'b0000;
               state      <= ADD;
            end
            ADD: begin
               sumReg  <= sumC;
               resSign <= (sumC == '0) ? 1'b0 : bigSign;
               state   <= NORM;
            end
            NORM: begin
               if (!forceEn) begin
                  if (sumReg[M]) begin
                     normSig <= sumReg[M:1] | {{(M-1){1'b0}}, sumReg[0]};
                     expReg  <= expReg + EXP_ONE;
                  end else if (sumReg == '0) begin
                     forceEn    <= 1'b1;
                     forceRes   <= '0;
                     forceFlags <= 4'b0000;
                  end else if (normExpC[XW-1] || (normExpC == '0)) begin
                     forceEn    <= 1'b1;
                     forceRes   <= {resSign, {(W-1){1'b0}}};
                     forceFlags <= 4'b0011;
                  end else begin
                     normSig <= normShifted;
                     expReg  <= normExpC;
                  end
               end
               state <= ROUND;
            end
            ROUND: begin
               result <= forceEn ? forceRes : roundRes;
               flags  <= forceEn ? forceFlags : roundFlags;
               state  <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_suma_pf_seq.sv
`timescale 1ns/1ps
module tb_suma_pf_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstN;
   logic        inValid, inReady, op, outValid, outReady;
   logic [31:0] a, b, result;
   logic [3:0]  flags;

   logic        hInValid, hInReady, hOp, hOutValid, hOutReady;
   logic [15:0] hA, hB, hResult;
   logic [3:0]  hFlags;

   int checks   = 0;
   int failures = 0;

   suma_pf_seq dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
      .a(a), .b(b), .op(op), .out_valid(outValid), .out_ready(outReady),
      .result(result), .flags(flags)
   );

   suma_pf_seq #(.EXP_W(5), .MAN_W(10)) dutH (
      .clk(clk), .rst_n(rstN), .in_valid(hInValid), .in_ready(hInReady),
      .a(hA), .b(hB), .op(hOp), .out_valid(hOutValid), .out_ready(hOutReady),
      .result(hResult), .flags(hFlags)
   );

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        vop;
      logic [31:0] expRes;
      logic [3:0]  expFlg;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out", name);
   endtask

   // Exact integer model of a correctly rounded single-precision add.
   function automatic logic [35:0] refAdd(input logic [31:0] x, input logic [31:0] y, input logic opv);
      logic   sx, sy, sgn, inx;
      int     ex, ey, emin, p, e, sh;
      longint vx, vy, s, n, keep, rem;
      sx = x[31];
      sy = y[31] ^ opv;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return {32'h7FC00000, 4'b1000};
      if (ex == 255 && ey == 255 && sx != sy) return {32'h7FC00000, 4'b1000};
      if (ex == 255) return {sx, 8'hFF, 23'h0, 4'b0000};
      if (ey == 255) return {sy, 8'hFF, 23'h0, 4'b0000};
      if (ex == 0 && ey == 0) return 36'h0;
      emin = (ex == 0) ? ey : (ey == 0) ? ex : ((ex < ey) ? ex : ey);
      vx = (ex == 0) ? 64'sd0 : (longint'({1'b1, x[22:0]}) << (ex - emin));
      vy = (ey == 0) ? 64'sd0 : (longint'({1'b1, y[22:0]}) << (ey - emin));
      s = (sx ? -vx : vx) + (sy ? -vy : vy);
      if (s == 0) return 36'h0;
      sgn = (s < 0);
      n = sgn ? -s : s;
      p = 0;
      for (int i = 0; i < 63; i++) if (((n >> i) & 1) != 0) p = i;
      e = emin + p - 23;
      if (e <= 0) return {sgn, 31'h0, 4'b0011};
      rem = 0;
      if (p > 23) begin
         sh   = p - 23;
         keep = n >> sh;
         rem  = n & ((longint'(1) << sh) - 1);
      end else begin
         keep = n << (23 - p);
      end
      inx = (rem != 0);
`ifdef SUMA_PF_RNE_EN
      if (p > 23) begin
         longint half;
         half = longint'(1) << (p - 24);
         if ((rem & half) != 0 && (((rem & (half - 1)) != 0) || ((keep & 1) != 0))) keep++;
      end
`endif
      if (keep == (longint'(1) << 24)) begin
         keep = longint'(1) << 23;
         e++;
      end
      if (e >= 255) begin
`ifdef SUMA_PF_RNE_EN
         return {sgn, 8'hFF, 23'h0, 4'b0101};
`else
         return {sgn, 8'hFE, 23'h7FFFFF, 4'b0101};
`endif
      end
      return {sgn, 8'(e), 23'(keep), 3'b000, inx};
   endfunction

   task automatic runOp(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                        output logic [31:0] res, output logic [3:0] flg, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!inReady && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!inReady) timeoutFail("inReadyWait");
      inValid = 1'b1;
      a = ta;
      b = tbv;
      op = top;
      @(posedge clk);
      #1 inValid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (outValid) break;
      end
      if (!outValid) timeoutFail("outValidWait");
      res = result;
      flg = flags;
      outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
   endtask

   task automatic runOpH(input logic [15:0] ta, input logic [15:0] tbv, input logic top,
                         output logic [15:0] res, output logic [3:0] flg, output int lat);
      @(negedge clk);
      if (!hInReady) timeoutFail("hInReadyWait");
      hInValid = 1'b1;
      hA = ta;
      hB = tbv;
      hOp = top;
      @(posedge clk);
      #1 hInValid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (hOutValid) break;
      end
      if (!hOutValid) timeoutFail("hOutValidWait");
      res = hResult;
      flg = hFlags;
      hOutReady = 1'b1;
      @(posedge clk);
      #1 hOutReady = 1'b0;
   endtask

   function automatic logic [31:0] mkOp(input int e, input logic s);
      logic [31:0] r;
      r = $urandom();
      return {s, 8'(e), r[22:0]};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res, ta, tbv, r32;
      logic [15:0] hRes;
      logic [3:0]  flg;
      logic [35:0] expv;
      logic        top;
      int          lat, e1, e2, k, guard;

`ifdef SUMA_PF_RNE_EN
      localparam logic [31:0] TIE_RES  = 32'h3F800002;
      localparam logic [31:0] OVF_RES  = 32'h7F800000;
      localparam logic [31:0] ONEM_RES = 32'h3F800000;
`else
      localparam logic [31:0] TIE_RES  = 32'h3F800001;
      localparam logic [31:0] OVF_RES  = 32'h7F7FFFFF;
      localparam logic [31:0] ONEM_RES = 32'h3F7FFFFF;
`endif
      vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
      vecs[1]  = '{32'h3FC00000, 32'hC0200000, 1'b0, 32'hBF800000, 4'b0000};
      vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
      vecs[3]  = '{32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000};
      vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, TIE_RES,      4'b0001};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, OVF_RES,      4'b0101};
      vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
      vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
      vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
      vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
      vecs[10] = '{32'h00C00000, 32'h80800000, 1'b0, 32'h00000000, 4'b0011};
      vecs[11] = '{32'h3F800000, 32'h80800000, 1'b0, ONEM_RES,     4'b0001};
      vecs[12] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
      vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
      vecs[14] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};
      vecs[15] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000};

      rstN = 1'b0;
      inValid = 1'b0; outReady = 1'b0; op = 1'b0; a = '0; b = '0;
      hInValid = 1'b0; hOutReady = 1'b0; hOp = 1'b0; hA = '0; hB = '0;
      #22;
      chk("rstInReady", inReady, 1);
      chk("rstOutValid", outValid, 0);
      chk("rstResult", result, 0);
      chk("rstFlags", flags, 0);
      chk("rstHInReady", hInReady, 1);
      chk("rstHResult", hResult, 0);
      @(negedge clk);
      rstN = 1'b1;

      // directed table
      for (int i = 0; i < NV; i++) begin
         runOp(vecs[i].va, vecs[i].vb, vecs[i].vop, res, flg, lat);
         chk($sformatf("vec%0d_result", i), res, vecs[i].expRes);
         chk($sformatf("vec%0d_flags", i), flg, vecs[i].expFlg);
         chk($sformatf("vec%0d_latency", i), lat, 4);
      end

      // randomized against the exact model
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 15);
         e1 = (k == 2) ? $urandom_range(1, 4) : (k == 3) ? $urandom_range(250, 254) : $urandom_range(1, 254);
         if (k == 0) ta = mkOp(0, 1'($urandom_range(0, 1)));
         else if (k == 1) begin
            ta = mkOp(255, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) ta[22:0] = '0;
         end else ta = mkOp(e1, 1'($urandom_range(0, 1)));
         k = $urandom_range(0, 9);
         if (k == 0) begin
            r32 = $urandom();
            tbv = {r32[31], ta[30:4], r32[3:0]};
         end else if (k == 1) tbv = mkOp(0, 1'($urandom_range(0, 1)));
         else if (k == 2) begin
            tbv = mkOp(255, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) tbv[22:0] = '0;
         end else begin
            e2 = e1 + $urandom_range(0, 60) - 30;
            if (e2 < 1) e2 = 1;
            if (e2 > 254) e2 = 254;
            tbv = mkOp(e2, 1'($urandom_range(0, 1)));
         end
         top = 1'($urandom_range(0, 1));
         expv = refAdd(ta, tbv, top);
         runOp(ta, tbv, top, res, flg, lat);
         chk($sformatf("rand%0d_%h_%h_%0d", i, ta, tbv, top), {res, flg}, expv);
      end

      // backpressure: hold DONE, poke in_valid with other operands
      @(negedge clk);
      inValid = 1'b1; a = 32'h3FC00000; b = 32'h3FC00000; op = 1'b0;
      @(posedge clk);
      #1 inValid = 1'b0;
      guard = 0;
      @(negedge clk);
      while (!outValid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!outValid) timeoutFail("bpOutValidWait");
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bpResult%0d", i), result, 32'h40400000);
         chk($sformatf("bpFlags%0d", i), flags, 0);
         chk($sformatf("bpInReady%0d", i), inReady, 0);
         chk($sformatf("bpOutValid%0d", i), outValid, 1);
         inValid = 1'b1; a = $urandom(); b = $urandom(); op = 1'b1;
         @(negedge clk);
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
      chk("bpIdleInReady", inReady, 1);
      chk("bpIdleOutValid", outValid, 0);
      runOp(32'h40400000, 32'h3F800000, 1'b1, res, flg, lat);
      chk("bpNextResult", res, 32'h40000000);
      chk("bpNextLatency", lat, 4);

      // reset while in NORM
      runOp(32'h3F800000, 32'h3F800000, 1'b0, res, flg, lat);
      chk("preRstResult", res, 32'h40000000);
      @(negedge clk);
      inValid = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = 1'b0;
      @(posedge clk);
      #1 inValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("normBusy", inReady, 0);
      rstN = 1'b0;
      #1;
      chk("midRstInReady", inReady, 1);
      chk("midRstOutValid", outValid, 0);
      chk("midRstResult", result, 0);
      chk("midRstFlags", flags, 0);
      @(negedge clk);
      rstN = 1'b1;
      runOp(32'h3F800000, 32'h40000000, 1'b0, res, flg, lat);
      chk("postRstResult", res, 32'h40400000);
      chk("postRstFlags", flg, 0);
      chk("postRstLatency", lat, 4);

      // half-width instance
      runOpH(16'h3C00, 16'h3C00, 1'b0, hRes, flg, lat);
      chk("halfAddResult", hRes, 16'h4000);
      chk("halfAddFlags", flg, 0);
      chk("halfAddLatency", lat, 4);
      runOpH(16'h4000, 16'h3C00, 1'b1, hRes, flg, lat);
      chk("halfSubResult", hRes, 16'h3C00);
      chk("halfSubFlags", flg, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
